// File: rtl/apb_node_pipe_pkg.sv
// Shared types for the registered APB 1-to-N node: FSM states and the address rule record.
package apb_node_pipe_pkg;

  // Rule addresses are stored at a fixed width so the record is independent of the node's address width.
  localparam int unsigned RULE_ADDR_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    MSETUP,
    MACCESS,
    RESP
  } state_e;

  typedef struct packed {
    logic [RULE_ADDR_W-1:0] start_addr;
    logic [RULE_ADDR_W-1:0] end_addr;
    logic                   en;
  } rule_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: inclusive unsigned range match, lowest enabled rule index wins.
module apb_addr_decode
  import apb_node_pipe_pkg::*;
#(
  parameter int unsigned NB_RULES = 8,
  parameter int unsigned IDX_W    = idx_width(NB_RULES)
) (
  input  logic [RULE_ADDR_W-1:0] addr_i,
  input  rule_t [NB_RULES-1:0]   rules_i,
  output logic                   hit_o,
  output logic [IDX_W-1:0]       idx_o
);

  // Scanning from the top down lets the lowest matching index overwrite the others.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int k = int'(NB_RULES) - 1; k >= 0; k--) begin
      if (rules_i[k].en &&
          (addr_i >= rules_i[k].start_addr) &&
          (addr_i <= rules_i[k].end_addr)) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/apb_node_pipe.sv
// Registered APB 1-to-N node: decodes one bridge transfer, replays it on a single master port
// from flops, and returns the response with error reporting for unmapped and timed-out accesses.
module apb_node_pipe
  import apb_node_pipe_pkg::*;
#(
  parameter int unsigned NB_MASTER      = 8,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_CNT_W       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          psel_i,
  input  logic                                          penable_i,
  input  logic                                          pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0]                     paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]                     pwdata_i,
  input  logic [APB_DATA_WIDTH/8-1:0]                   pstrb_i,
  input  logic [2:0]                                    pprot_i,
  output logic [APB_DATA_WIDTH-1:0]                     prdata_o,
  output logic                                          pready_o,
  output logic                                          pslverr_o,
  output logic [NB_MASTER-1:0]                          psel_o,
  output logic                                          penable_o,
  output logic                                          pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]                     paddr_o,
  output logic [APB_DATA_WIDTH-1:0]                     pwdata_o,
  output logic [APB_DATA_WIDTH/8-1:0]                   pstrb_o,
  output logic [2:0]                                    pprot_o,
  input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0]      prdata_i,
  input  logic [NB_MASTER-1:0]                          pready_i,
  input  logic [NB_MASTER-1:0]                          pslverr_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]      start_addr_i,
  input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]      end_addr_i,
  input  logic [NB_MASTER-1:0]                          rule_en_i,
  output logic                                          timeout_o
);

  localparam int unsigned STRB_W   = APB_DATA_WIDTH / 8;
  localparam int unsigned IDX_W    = idx_width(NB_MASTER);
  localparam int unsigned CNT_W    = (TO_CNT_W > 0) ? TO_CNT_W : 1;
  localparam int unsigned TO_LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  state_e                    state_q, state_d;
  logic [NB_MASTER-1:0]      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0]         pstrb_q, pstrb_d;
  logic [2:0]                pprot_q, pprot_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      timeout_q, timeout_d;
  logic                      resp_done_q, resp_done_d;

  rule_t [NB_MASTER-1:0]     rules;
  logic                      dec_hit;
  logic [IDX_W-1:0]          dec_idx;
  logic                      to_hit;

  always_comb begin
    rules = '0;
    for (int k = 0; k < int'(NB_MASTER); k++) begin
      rules[k].start_addr = RULE_ADDR_W'(start_addr_i[k]);
      rules[k].end_addr   = RULE_ADDR_W'(end_addr_i[k]);
      rules[k].en         = rule_en_i[k];
    end
  end

  apb_addr_decode #(
    .NB_RULES (NB_MASTER),
    .IDX_W    (IDX_W)
  ) u_decode (
    .addr_i  (RULE_ADDR_W'(paddr_i)),
    .rules_i (rules),
    .hit_o   (dec_hit),
    .idx_o   (dec_idx)
  );

  assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LIMIT));

  // resp_done_q blocks re-accepting a bridge access phase still held in the cycle after RESP.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    idx_d       = idx_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
    resp_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (psel_i && penable_i && !resp_done_q) begin
          pwrite_d = pwrite_i;
          paddr_d  = paddr_i;
          pwdata_d = pwdata_i;
          pstrb_d  = pstrb_i;
          pprot_d  = pprot_i;
          rdata_d  = '0;
          if (dec_hit) begin
            psel_d          = '0;
            psel_d[dec_idx] = 1'b1;
            penable_d       = 1'b0;
            idx_d           = dec_idx;
            err_d           = 1'b0;
            state_d         = MSETUP;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end

      MSETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = MACCESS;
      end

      MACCESS: begin
        // A ready peripheral takes precedence over an expiring watchdog in the same cycle.
        if (pready_i[idx_q]) begin
          rdata_d   = pwrite_q ? '0 : prdata_i[idx_q];
          err_d     = pslverr_i[idx_q];
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = RESP;
        end else if (to_hit) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        rdata_d     = '0;
        err_d       = 1'b0;
        resp_done_d = 1'b1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      idx_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      resp_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      idx_q       <= idx_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      resp_done_q <= resp_done_d;
    end
  end

  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign pstrb_o   = pstrb_q;
  assign pprot_o   = pprot_q;
  assign timeout_o = timeout_q;

  assign pready_o  = (state_q == RESP);
  assign pslverr_o = (state_q == RESP) ? err_q : 1'b0;
  assign prdata_o  = (state_q == RESP) ? rdata_q : '0;

endmodule
